// File: rtl/sdf_pkg.sv
// Shared constants and helpers for the SDF NTT sequencer (stage delays, bit reversal).
package sdf_pkg;

  localparam int LOG_N_DEF = 3;
  localparam int N         = 1 << LOG_N_DEF;
  localparam int TW_AW     = LOG_N_DEF - 1;

  typedef enum logic {
    IN_IDLE  = 1'b0,
    IN_FRAME = 1'b1
  } in_state_e;

  function automatic int stage_delay(input int s, input int log_n);
    return 1 << (log_n - 1 - s);
  endfunction

  function automatic int unsigned bitrev(input int unsigned x, input int log_n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < log_n; i++) begin
      r = (r << 1) | ((x >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_stage_seq.sv
// Control for one SDF stage: phase counter, buffer mux selects, twiddle address
// and the valid/sop delay line that feeds the next stage.
module sdf_stage_seq
  import sdf_pkg::*;
#(
  parameter int LOG_N   = 3,
  parameter int STAGE   = 0,
  parameter int BFU_LAT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             v_i,
  input  logic             sop_i,
  output logic             v_o,
  output logic             sop_o,
  output logic             buf_in_sel_o,
  output logic             buf_out_sel_o,
  output logic [LOG_N-2:0] tw_addr_o,
  output logic             busy_o
);

  localparam int AW = LOG_N - 1;
  localparam int D  = stage_delay(STAGE, LOG_N);
  localparam int DL = D + BFU_LAT;
  localparam int PB = LOG_N - 1 - STAGE;
  localparam logic [AW-1:0] TW_MASK = AW'(D - 1);

  logic [LOG_N-1:0] c_q, c_d, c_cur;
  logic             bfly;
  logic [AW-1:0]    tw_raw;
  logic [DL-1:0]    v_sr_q, sop_sr_q;

  // A frame's first sample realigns the counter so an aborted frame cannot skew the phase.
  assign c_cur  = sop_i ? '0 : c_q;
  assign bfly   = v_i & c_cur[PB];
  assign tw_raw = bfly ? ((c_cur[AW-1:0] & TW_MASK) << STAGE) : '0;
  assign c_d    = v_i ? c_cur + 1'b1 : c_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q      <= '0;
      v_sr_q   <= '0;
      sop_sr_q <= '0;
    end else begin
      c_q      <= c_d;
      v_sr_q   <= DL'({v_sr_q, v_i});
      sop_sr_q <= DL'({sop_sr_q, sop_i});
    end
  end

  assign v_o    = v_sr_q[DL-1];
  assign sop_o  = sop_sr_q[DL-1];
  assign busy_o = |v_sr_q;

  generate
    if (BFU_LAT == 0) begin : g_nolat
      assign buf_out_sel_o = bfly;
      assign buf_in_sel_o  = ~bfly;
      assign tw_addr_o     = tw_raw;
    end else begin : g_lat
      // Selects and twiddle follow the butterfly result through the bfu pipeline.
      logic [BFU_LAT-1:0] bf_sr_q;
      logic [AW-1:0]      tw_sr_q [BFU_LAT];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          bf_sr_q <= '0;
          for (int i = 0; i < BFU_LAT; i++) tw_sr_q[i] <= '0;
        end else begin
          bf_sr_q    <= BFU_LAT'({bf_sr_q, bfly});
          tw_sr_q[0] <= tw_raw;
          for (int i = 1; i < BFU_LAT; i++) tw_sr_q[i] <= tw_sr_q[i-1];
        end
      end

      assign buf_out_sel_o = bf_sr_q[BFU_LAT-1];
      assign buf_in_sel_o  = ~bf_sr_q[BFU_LAT-1];
      assign tw_addr_o     = tw_sr_q[BFU_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/sdf_ntt_ctrl.sv
// Sequencer for a radix-2 SDF NTT chain: frame tracking, protocol errors, per-stage control.
// Define SDF_BITREV_EN to add out_idx, the natural-order index of each DIF output sample.
module sdf_ntt_ctrl
  import sdf_pkg::*;
#(
  parameter int LOG_N   = LOG_N_DEF,
  parameter int BFU_LAT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sop,
  output logic [LOG_N-1:0]           buf_in_sel,
  output logic [LOG_N-1:0]           buf_out_sel,
  output logic [LOG_N*(LOG_N-1)-1:0] tw_addr,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       busy,
  output logic                       err
`ifdef SDF_BITREV_EN
  ,
  output logic [LOG_N-1:0]           out_idx
`endif
);

  localparam int AW = LOG_N - 1;
  localparam logic [LOG_N-1:0] CNT_LAST = '1;

  // in_valid qualifies one sample per cycle and in_sop marks a frame's first sample;
  // there is no backpressure, so every accepted sample must flow on every cycle.
  in_state_e        state_q, state_d;
  logic [LOG_N-1:0] in_cnt_q, in_cnt_d;
  logic             accept, sop_acc, err_set, err_q;
  logic [LOG_N:0]   v_chain, sop_chain;
  logic [LOG_N-1:0] stage_busy;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    accept   = 1'b0;
    sop_acc  = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      IN_IDLE: begin
        if (in_valid) begin
          if (in_sop) begin
            accept   = 1'b1;
            sop_acc  = 1'b1;
            in_cnt_d = in_cnt_q + 1'b1;
            state_d  = IN_FRAME;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      IN_FRAME: begin
        if (in_valid) begin
          accept   = 1'b1;
          err_set  = in_sop;
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == CNT_LAST) state_d = IN_IDLE;
        end else begin
          err_set  = 1'b1;
          in_cnt_d = '0;
          state_d  = IN_IDLE;
        end
      end
      default: begin
        state_d  = IN_IDLE;
        in_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IN_IDLE;
      in_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      err_q    <= err_q | err_set;
    end
  end

  assign v_chain[0]   = accept;
  assign sop_chain[0] = sop_acc;

  for (genvar s = 0; s < LOG_N; s++) begin : g_stage
    sdf_stage_seq #(
      .LOG_N  (LOG_N),
      .STAGE  (s),
      .BFU_LAT(BFU_LAT)
    ) u_seq (
      .clk_i        (clk),
      .rst_i        (rst),
      .v_i          (v_chain[s]),
      .sop_i        (sop_chain[s]),
      .v_o          (v_chain[s+1]),
      .sop_o        (sop_chain[s+1]),
      .buf_in_sel_o (buf_in_sel[s]),
      .buf_out_sel_o(buf_out_sel[s]),
      .tw_addr_o    (tw_addr[s*AW +: AW]),
      .busy_o       (stage_busy[s])
    );
  end

  assign out_valid = v_chain[LOG_N];
  assign out_sop   = sop_chain[LOG_N];
  assign busy      = (in_cnt_q != '0) | (|stage_busy);
  assign err       = err_q;

`ifdef SDF_BITREV_EN
  logic [LOG_N-1:0] oidx_q, oidx_cur;

  assign oidx_cur = out_sop ? '0 : oidx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oidx_q <= '0;
    end else if (out_valid) begin
      oidx_q <= oidx_cur + 1'b1;
    end
  end

  assign out_idx = LOG_N'(bitrev(32'(oidx_cur), LOG_N));
`endif

endmodule

// File: tb/tb_sdf_ntt_ctrl.sv
// Directed bench for sdf_ntt_ctrl at LOG_N=3, BFU_LAT=0 with an output scoreboard
// and a per-cycle selector/twiddle table for the single-frame case.
module tb_sdf_ntt_ctrl;
  import sdf_pkg::*;

  localparam int LN  = LOG_N_DEF;
  localparam int LAT = N - 1;
  localparam int TWW = LN * TW_AW;
  localparam int OW  = 32 + LN + 1;
  localparam int SW  = 32 + 2 * LN + TWW;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_sop;
  logic [LN-1:0]  buf_in_sel, buf_out_sel;
  logic [TWW-1:0] tw_addr;
  logic           out_valid, out_sop, busy, err;
`ifdef SDF_BITREV_EN
  logic [LN-1:0]  out_idx;
`endif

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          m_cnt;
  logic        m_err;
  int unsigned base;

  logic [OW-1:0] exp_q[$];
  logic [SW-1:0] sel_q[$];

  logic [LN-1:0]  brev_tbl [N]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [LN-1:0]  sel_bos  [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd7,
                                    3'd0, 3'd4, 3'd2, 3'd6, 3'd0, 3'd4, 3'd0, 3'd0};
  logic [TWW-1:0] sel_tw   [16] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd11,
                                    6'd0, 6'd0, 6'd0, 6'd8, 6'd0, 6'd0, 6'd0, 6'd0};

  sdf_ntt_ctrl #(.LOG_N(LN), .BFU_LAT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .buf_in_sel (buf_in_sel),
    .buf_out_sel(buf_out_sel),
    .tw_addr    (tw_addr),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .busy       (busy),
    .err        (err)
`ifdef SDF_BITREV_EN
    ,
    .out_idx    (out_idx)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: one input cycle; the bench model decides acceptance and expected outputs
  task automatic drive(input logic v, input logic s);
    @(posedge clk);
    #1;
    check("err", err, m_err);
    in_valid = v;
    in_sop   = s;
    if (v) begin
      if (m_cnt == 0) begin
        if (s) begin
          exp_q.push_back({32'(cyc + LAT), brev_tbl[0], 1'b1});
          m_cnt = 1;
        end else begin
          m_err = 1'b1;
        end
      end else begin
        exp_q.push_back({32'(cyc + LAT), brev_tbl[m_cnt], 1'b0});
        if (s) m_err = 1'b1;
        m_cnt = (m_cnt == N - 1) ? 0 : m_cnt + 1;
      end
    end else if (m_cnt != 0) begin
      m_err = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic send_frame(input int stray_at);
    drive(1'b1, 1'b1);
    for (int i = 1; i < N; i++) drive(1'b1, i == stray_at);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || sel_q.size() != 0 || busy !== 1'b0) && n < 100);
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs, %0d selector steps still pending", exp_q.size(), sel_q.size());
      exp_q.delete();
      sel_q.delete();
    end
  endtask

  // scoreboard monitor: output samples
  always @(negedge clk) begin : out_mon
    logic [OW-1:0] e;
    if (rst !== 1'b1) begin
      if (!out_valid && exp_q.size() != 0 && exp_q[0][OW-1 -: 32] == cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_missing: out_valid=0 at cycle %0d, expected a sample", cyc);
        void'(exp_q.pop_front());
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: out_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_cycle", cyc, e[OW-1 -: 32]);
          check("out_sop", out_sop, e[0]);
`ifdef SDF_BITREV_EN
          check("out_idx", out_idx, e[LN:1]);
`endif
        end
      end
    end
  end

  // scoreboard monitor: per-cycle selectors and twiddle addresses
  always @(negedge clk) begin : sel_mon
    logic [SW-1:0] e;
    if (rst !== 1'b1 && sel_q.size() != 0 && sel_q[0][SW-1 -: 32] == cyc) begin
      e = sel_q.pop_front();
      check("buf_in_sel", buf_in_sel, e[TWW + 2*LN - 1 -: LN]);
      check("buf_out_sel", buf_out_sel, e[TWW + LN - 1 -: LN]);
      check("tw_addr", tw_addr, e[TWW-1:0]);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    m_cnt    = 0;
    m_err    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_buf_in_sel", buf_in_sel, 3'b111);
    check("rst_buf_out_sel", buf_out_sel, 3'b000);
    check("rst_tw_addr", tw_addr, 6'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sop", out_sop, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // single frame with the full selector/twiddle table
    base = cyc + 1;
    for (int r = 0; r < 16; r++)
      sel_q.push_back({32'(base + r), ~sel_bos[r], sel_bos[r], sel_tw[r]});
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    check("busy_mid_frame", busy, 1'b1);
    for (int i = 2; i < N; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    wait_idle();
    check("single_busy_end", busy, 1'b0);
    check("single_err_end", err, 1'b0);

    // back-to-back frames
    send_frame(-1);
    send_frame(-1);
    drive(1'b0, 1'b0);
    wait_idle();
    check("b2b_err", err, 1'b0);
    check("b2b_busy_end", busy, 1'b0);

    // orphan sample, a frame, then asynchronous reset mid-run at cycle 10
    drive(1'b1, 1'b0);
    send_frame(-1);
    drive(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", out_valid, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_err", err, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_out_sop", out_sop, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_err", err, 1'b0);
    check("async_rst_buf_in_sel", buf_in_sel, 3'b111);
    check("async_rst_buf_out_sel", buf_out_sel, 3'b000);
    check("async_rst_tw_addr", tw_addr, 6'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // gap inside a frame aborts it; accepted samples still drain
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    wait_idle();
    check("gap_busy_cleared", busy, 1'b0);
    check("gap_err_sticky", err, 1'b1);

    // stray sop at position 5 is ignored; the next frame starts right after sample 7
    send_frame(5);
    send_frame(-1);
    drive(1'b0, 1'b0);
    wait_idle();
    check("stray_err_sticky", err, 1'b1);
    check("stray_busy_end", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
